// File: rtl/audio_pkg.sv
// Shared audio types and I2S constants for the compressor output path.
// Pure declarations: no timing, no handshake.
package audio_pkg;
   localparam int AUDIO_SAMPLE_WIDTH = 16;
   localparam int DEF_SLOT_WIDTH     = 32;
   localparam int DEF_BCLK_DIV       = 16;
   localparam logic I2S_LEFT         = 1'b0;

   typedef logic signed [AUDIO_SAMPLE_WIDTH-1:0] audio_sample_t;

   typedef struct packed {
      audio_sample_t l;
      audio_sample_t r;
   } stereo_pair_t;

   // Word select for frame bit b: Philips format leads each channel by one bit.
   function automatic logic ws_for_bit(input int unsigned b, input int unsigned slot_width);
      return (b >= slot_width - 1 && b <= 2 * slot_width - 2) ? ~I2S_LEFT : I2S_LEFT;
   endfunction
endpackage

// File: rtl/audio_i2s_tx_if.sv
// Stereo sample handshake into the I2S transmitter (valid/ready, one pair per beat).
// Source holds the pair stable while valid and not ready.
interface audio_i2s_tx_if #(
   parameter int SAMPLE_WIDTH = 16
) ();
   logic [SAMPLE_WIDTH-1:0] audio_l_i;
   logic [SAMPLE_WIDTH-1:0] audio_r_i;
   logic                    sample_valid_i;
   logic                    sample_ready_o;

   modport master (
      output audio_l_i,
      output audio_r_i,
      output sample_valid_i,
      input  sample_ready_o
   );

   modport slave (
      input  audio_l_i,
      input  audio_r_i,
      input  sample_valid_i,
      output sample_ready_o
   );
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV/2 cycles; ticks flag the toggling cycle.
// Ticks are combinational and coincide with the cycle whose clock edge toggles bclk.
module i2s_bclk_gen #(
   parameter int BCLK_DIV = 16
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic enable_i,
   output logic bclk_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);
   localparam int HALF = BCLK_DIV / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] TERM = CW'(HALF - 1);

   logic [CW-1:0] cnt_q;
   logic          term;

   assign term        = enable_i && (cnt_q == TERM);
   assign rise_tick_o = term && !bclk_o;
   assign fall_tick_o = term && bclk_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q  <= '0;
         bclk_o <= 1'b0;
      end else if (!enable_i) begin
         cnt_q  <= '0;
         bclk_o <= 1'b0;
      end else if (term) begin
         cnt_q  <= '0;
         bclk_o <= ~bclk_o;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S (Philips) stereo serialiser with a one-entry holding register; ready = hold empty.
// A pair accepted now goes out from the next frame boundary; starved frames repeat the last pair.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
   parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
   parameter int BCLK_DIV     = DEF_BCLK_DIV
) (
   input  logic           clk_i,
   input  logic           reset_n_i,
   input  logic           enable_i,
   audio_i2s_tx_if.slave  smp,
   output logic           i2s_bclk_o,
   output logic           i2s_lrclk_o,
   output logic           i2s_sdata_o,
   output logic           frame_start_o,
   output logic           underrun_o
);
   localparam int FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int BW         = $clog2(FRAME_BITS);
   localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] SLOT_B = BW'(SLOT_WIDTH);

   typedef struct packed {
      logic [SAMPLE_WIDTH-1:0] l;
      logic [SAMPLE_WIDTH-1:0] r;
   } pair_t;

   pair_t                   hold_q, last_q, frame_q, frame_nxt;
   logic                    hold_full_q;
   logic [BW-1:0]           b_q, b_nxt, pos;
   logic [SAMPLE_WIDTH-1:0] ch, shifted;
   logic                    fall_tick, load, accept;
   logic                    unused_rise_tick;

   i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .enable_i    (enable_i),
      .bclk_o      (i2s_bclk_o),
      .rise_tick_o (unused_rise_tick),
      .fall_tick_o (fall_tick)
   );

   assign smp.sample_ready_o = ~hold_full_q;
   assign accept    = smp.sample_valid_i && !hold_full_q;
   assign b_nxt     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
   assign load      = fall_tick && (b_nxt == '0);
   assign frame_nxt = load ? (hold_full_q ? hold_q : last_q) : frame_q;

   // Left-justify within the slot: shifting past the sample width yields the zero padding.
   always_comb begin
      pos = b_nxt;
      ch  = frame_nxt.l;
      if (b_nxt >= SLOT_B) begin
         pos = b_nxt - SLOT_B;
         ch  = frame_nxt.r;
      end
      shifted = ch << pos;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         b_q           <= B_LAST;
         i2s_lrclk_o   <= I2S_LEFT;
         i2s_sdata_o   <= 1'b0;
         frame_start_o <= 1'b0;
         underrun_o    <= 1'b0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         last_q        <= '0;
         frame_q       <= '0;
      end else begin
         frame_start_o <= 1'b0;
         underrun_o    <= 1'b0;
         // Load drains a full register; accept only fills an empty one, so they never collide.
         if (load && hold_full_q) begin
            hold_full_q <= 1'b0;
         end else if (accept) begin
            hold_full_q <= 1'b1;
            hold_q      <= {smp.audio_l_i, smp.audio_r_i};
         end
         if (load) begin
            frame_q       <= frame_nxt;
            last_q        <= frame_nxt;
            frame_start_o <= 1'b1;
            underrun_o    <= ~hold_full_q;
         end
         if (!enable_i) begin
            b_q         <= B_LAST;
            i2s_lrclk_o <= I2S_LEFT;
            i2s_sdata_o <= 1'b0;
         end else if (fall_tick) begin
            b_q         <= b_nxt;
            i2s_lrclk_o <= ws_for_bit(32'(b_nxt), SLOT_WIDTH);
            i2s_sdata_o <= shifted[SAMPLE_WIDTH-1];
         end
      end
   end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench: dut_a (16-bit slots, BCLK_DIV 4) for framing/handshake/reset/enable,
// dut_b (32-bit slots) for slot padding.
module tb_audio_i2s_tx;
   import audio_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b1;
   always #5 clk = ~clk;

   audio_i2s_tx_if #(.SAMPLE_WIDTH(16)) if_a ();
   audio_i2s_tx_if #(.SAMPLE_WIDTH(16)) if_b ();

   logic bclk_a, lr_a, sd_a, fs_a, ur_a;
   logic bclk_b, lr_b, sd_b, fs_b, ur_b;

   audio_i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .BCLK_DIV(4)) dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .enable_i(en), .smp(if_a),
      .i2s_bclk_o(bclk_a), .i2s_lrclk_o(lr_a), .i2s_sdata_o(sd_a),
      .frame_start_o(fs_a), .underrun_o(ur_a)
   );

   audio_i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(4)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .enable_i(en), .smp(if_b),
      .i2s_bclk_o(bclk_b), .i2s_lrclk_o(lr_b), .i2s_sdata_o(sd_b),
      .frame_start_o(fs_b), .underrun_o(ur_b)
   );

   int checks = 0;
   int errors = 0;

   // lrclk high for b = 15..30, stored at index 31-b.
   localparam logic [31:0] LR_EXP = 32'h0001_FFFE;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic wait_fs_a(output logic ur);
      int n = 0;
      @(negedge clk);
      while (!fs_a && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!fs_a) check("fs_a_timeout", 0, 1);
      ur = ur_a;
   endtask

   task automatic wait_fs_b(output logic ur);
      int n = 0;
      @(negedge clk);
      while (!fs_b && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!fs_b) check("fs_b_timeout", 0, 1);
      ur = ur_b;
   endtask

   // Samples sdata/lrclk on each bclk rising edge, frame bit b stored at index 31-b.
   task automatic cap_a(output logic [31:0] d, output logic [31:0] lr, output int urx);
      int   n = 0;
      int   cyc = 0;
      logic prev = bclk_a;
      d = '0; lr = '0; urx = 0;
      while (n < 32 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (ur_a) urx++;
         if (bclk_a && !prev) begin
            d[31-n]  = sd_a;
            lr[31-n] = lr_a;
            n++;
         end
         prev = bclk_a;
      end
      if (n < 32) check("cap_a_timeout", 0, 1);
   endtask

   task automatic cap_b(output logic [63:0] d);
      int   n = 0;
      int   cyc = 0;
      logic prev = bclk_b;
      d = '0;
      while (n < 64 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (bclk_b && !prev) begin
            d[63-n] = sd_b;
            n++;
         end
         prev = bclk_b;
      end
      if (n < 64) check("cap_b_timeout", 0, 1);
   endtask

   task automatic send_a(input stereo_pair_t p);
      int n = 0;
      @(negedge clk);
      if_a.audio_l_i      = p.l;
      if_a.audio_r_i      = p.r;
      if_a.sample_valid_i = 1'b1;
      while (!if_a.sample_ready_o && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!if_a.sample_ready_o) check("send_a_timeout", 0, 1);
      @(negedge clk);
      if_a.sample_valid_i = 1'b0;
   endtask

   initial begin
      stereo_pair_t pp[7];
      logic [31:0]  d, lr;
      logic [63:0]  db;
      logic         u, ub;
      int           ux, fsn;

      pp[0] = 32'hA5F0_0F0F;
      pp[1] = 32'h1234_8765;
      pp[2] = 32'hC0DE_7E57;
      pp[3] = 32'h00FF_F00F;
      pp[4] = 32'h5A5A_3C3C;
      pp[5] = 32'hBEEF_0001;
      pp[6] = 32'hFACE_9999;

      if_a.audio_l_i = '0; if_a.audio_r_i = '0; if_a.sample_valid_i = 1'b0;
      if_b.audio_l_i = '0; if_b.audio_r_i = '0; if_b.sample_valid_i = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_bclk",  bclk_a, 0);
      check("rst_lrclk", lr_a, 0);
      check("rst_sdata", sd_a, 0);
      check("rst_ready", if_a.sample_ready_o, 1);
      check("rst_fs",    fs_a, 0);
      check("rst_ur",    ur_a, 0);
      rst_n = 1'b1;

      fork
         begin
            wait_fs_a(u);
            check("f0_ur", u, 1);
            fork
               cap_a(d, lr, ux);
               send_a(pp[0]);
            join
            check("f0_data", d, 0);
            check("f0_lr", lr, LR_EXP);
            wait_fs_a(u);
            check("f1_ur", u, 0);
            cap_a(d, lr, ux);
            check("f1_data", d, 32'hA5F0_0F0F);
            check("f1_lr", lr, LR_EXP);
            check("f1_urx", ux, 0);
         end
         begin
            wait_fs_b(ub);
            @(negedge clk);
            if_b.audio_l_i      = 16'h8000;
            if_b.audio_r_i      = 16'h0001;
            if_b.sample_valid_i = 1'b1;
            @(negedge clk);
            if_b.sample_valid_i = 1'b0;
            wait_fs_b(ub);
            check("pad_ur", ub, 0);
            cap_b(db);
            check("pad_data", db, 64'h8000_0000_0001_0000);
         end
      join

      // Starved frame repeats the last pair while three pairs stream in under backpressure.
      wait_fs_a(u);
      check("starve_ur", u, 1);
      fork
         begin
            cap_a(d, lr, ux);
            check("starve_data", d, 32'hA5F0_0F0F);
            for (int k = 1; k <= 3; k++) begin
               wait_fs_a(u);
               check($sformatf("bp_ur%0d", k), u, 0);
               cap_a(d, lr, ux);
               check($sformatf("bp_data%0d", k), d, 32'(pp[k]));
            end
         end
         begin
            @(negedge clk);
            if_a.audio_l_i      = pp[1].l;
            if_a.audio_r_i      = pp[1].r;
            if_a.sample_valid_i = 1'b1;
            for (int k = 1; k <= 3; k++) begin
               int n = 0;
               while (!if_a.sample_ready_o && n < 1000) begin
                  @(negedge clk);
                  n++;
               end
               if (k > 1) check($sformatf("bp_rdy_at_fs%0d", k), fs_a, 1);
               @(negedge clk);
               check($sformatf("bp_rdy_lo%0d", k), if_a.sample_ready_o, 0);
               if (k < 3) begin
                  if_a.audio_l_i = pp[k+1].l;
                  if_a.audio_r_i = pp[k+1].r;
               end else begin
                  if_a.sample_valid_i = 1'b0;
               end
            end
         end
      join

      wait_fs_a(u);
      check("ur6", u, 1);
      cap_a(d, lr, ux);
      check("ur6_data", d, 32'(pp[3]));
      check("ur6_urx", ux, 0);
      wait_fs_a(u);
      check("ur7", u, 1);
      cap_a(d, lr, ux);
      check("ur7_urx", ux, 0);

      // Valid presented exactly in the load cycle lands one frame later.
      wait_fs_a(u);
      repeat (127) @(negedge clk);
      if_a.audio_l_i      = pp[4].l;
      if_a.audio_r_i      = pp[4].r;
      if_a.sample_valid_i = 1'b1;
      @(negedge clk);
      if_a.sample_valid_i = 1'b0;
      check("same_fs", fs_a, 1);
      check("same_ur", ur_a, 1);
      check("same_rdy", if_a.sample_ready_o, 0);
      cap_a(d, lr, ux);
      check("same_data_old", d, 32'(pp[3]));
      wait_fs_a(u);
      check("same_next_ur", u, 0);
      cap_a(d, lr, ux);
      check("same_data_new", d, 32'(pp[4]));

      // Enable drop mid-frame at b=20; a pair accepted while idle goes out first.
      wait_fs_a(u);
      repeat (80) @(negedge clk);
      check("en_lr_before", lr_a, 1);
      en = 1'b0;
      @(negedge clk);
      check("en_bclk", bclk_a, 0);
      check("en_lrclk", lr_a, 0);
      check("en_sdata", sd_a, 0);
      send_a(pp[5]);
      check("en_rdy_held", if_a.sample_ready_o, 0);
      fsn = 0;
      repeat (40) begin
         @(negedge clk);
         if (fs_a || bclk_a) fsn++;
      end
      check("en_idle", fsn, 0);
      en = 1'b1;
      wait_fs_a(u);
      check("reen_ur", u, 0);
      cap_a(d, lr, ux);
      check("reen_data", d, 32'(pp[5]));
      check("reen_lr", lr, LR_EXP);

      // Asynchronous reset at b=20 with a pair pending.
      wait_fs_a(u);
      send_a(pp[6]);
      repeat (78) @(negedge clk);
      check("rst_mid_lr_before", lr_a, 1);
      check("rst_mid_rdy_before", if_a.sample_ready_o, 0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_bclk", bclk_a, 0);
      check("rst_mid_lrclk", lr_a, 0);
      check("rst_mid_sdata", sd_a, 0);
      check("rst_mid_rdy", if_a.sample_ready_o, 1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_fs_a(u);
      check("post_rst_ur", u, 1);
      cap_a(d, lr, ux);
      check("post_rst_data", d, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
